// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler sharing one T flip-flop among N_REQ requesters.
// Optional toggle statistics counter enabled by defining TFF_SCHED_STATS_EN.
module tff_toggle_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] cnt_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   t,
  output logic                   q,
`ifdef TFF_SCHED_STATS_EN
  output logic [15:0]            toggle_total,
`endif
  output logic                   busy
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;

  logic             pick_valid;
  logic [SEL_W-1:0] pick;
  logic [CNT_W-1:0] pick_cnt;

  // Scan from last+1 with wrap-around so the most recently served requester
  // is considered last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick_valid = 1'b0;
    pick       = last;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last) + k) % N_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick       = SEL_W'(idx);
      end
    end
    pick_cnt = cnt_in[int'(pick)*CNT_W +: CNT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      sel       <= '0;
      last      <= SEL_W'(N_REQ - 1);
      gnt       <= '0;
      done      <= '0;
      t         <= 1'b0;
      q         <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      q    <= q ^ t;
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel       <= pick;
            remaining <= pick_cnt;
            gnt       <= ONE_HOT0 << pick;
            busy      <= 1'b1;
            if (pick_cnt != '0) begin
              t     <= 1'b1;
              state <= ST_BURST;
            end else begin
              // Zero-length burst: grant and done share the single cycle.
              done  <= ONE_HOT0 << pick;
              state <= ST_DONE;
            end
          end
        end
        ST_BURST: begin
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            t     <= 1'b0;
            gnt   <= '0;
            done  <= ONE_HOT0 << sel;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt   <= '0;
          last  <= sel;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TFF_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_total <= '0;
    end else if (t && toggle_total != 16'hFFFF) begin
      toggle_total <= toggle_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Scoreboard bench for tff_toggle_scheduler: a transaction-level reference model
// predicts each burst; a negedge monitor checks outputs against the queue.
module tb_tff_toggle_scheduler;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] cnt_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           t;
  logic           q;
  logic           busy;
`ifdef TFF_SCHED_STATS_EN
  logic [15:0]    toggle_total;
`endif

  tff_toggle_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cnt_in       (cnt_in),
    .gnt          (gnt),
    .done         (done),
    .t            (t),
    .q            (q),
`ifdef TFF_SCHED_STATS_EN
    .toggle_total (toggle_total),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int cnt;
    int done_cyc;
    bit q_end;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one arbitration decision per free slot, computed from
  // the request vector and the last winner; predicts done cycle and final q.
  int m_last = N - 1;
  int m_next = 0;
  bit m_q = 1'b0;
  always @(posedge clk) begin
    int w;
    int c;
    int i;
    if (!rst_n) begin
      m_last  = N - 1;
      m_q     = 1'b0;
      m_next  = 0;
      m_total = 0;
      exp_q.delete();
    end else if (cyc >= m_next && req != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (w < 0 && req[i]) w = i;
      end
      c = int'(cnt_in[w*W +: W]);
      m_q = m_q ^ c[0];
      m_total = (m_total + c > 65535) ? 65535 : m_total + c;
      exp_q.push_back('{sel: w, cnt: c, done_cyc: cyc + 1 + c, q_end: m_q});
      m_last = w;
      m_next = cyc + c + 2;
    end
    cyc++;
  end

  // Monitor: compares every cycle against the head of the expectation queue.
  int t_seen = 0;
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] eg;
    logic [31:0] et;
    if (!rst_n) begin
      t_seen = 0;
    end else begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      eg = '0;
      et = '0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (cyc < e.done_cyc || e.cnt == 0) eg = 32'(1) << e.sel;
        if (cyc < e.done_cyc) et = 32'd1;
      end
      check("gnt", 32'(gnt), eg);
      check("t", 32'(t), et);
      if (t) t_seen++;
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_sel", 32'(done), 32'(1) << e.sel);
          check("done_cycle", cyc, e.done_cyc);
          check("t_count", t_seen, e.cnt);
          check("q_after_burst", 32'(q), 32'(e.q_end));
        end
        t_seen = 0;
      end
    end
  end

  task automatic set_cnt(input int i, input int v);
    cnt_in[i*W +: W] = W'(v);
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < budget);
    check("wait_done", 32'(done[i]), 32'd1);
  endtask

  initial begin
    int grants;
    int n;
    int v;
    rst_n  = 1'b0;
    req    = '0;
    cnt_in = '0;
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_t", 32'(t), 32'd0);
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, cnt=3: q ends at 1.
    set_cnt(0, 3);
    req = 4'b0001;
    wait_done(0, 20);
    req = '0;
    check("q_after_cnt3", 32'(q), 32'd1);
    repeat (2) @(negedge clk);

    // All requesters, cnt=1, held for two full rounds.
    for (int i = 0; i < N; i++) set_cnt(i, 1);
    req = '1;
    grants = 0;
    n = 0;
    while (grants < 2 * N && n < 100) begin
      @(negedge clk);
      n++;
      if (done != '0) grants++;
    end
    check("round_robin_grants", grants, 2 * N);
    req = '0;
    repeat (3) @(negedge clk);

    // Zero-length burst on requester 2.
    set_cnt(2, 0);
    req = 4'b0100;
    wait_done(2, 10);
    req = '0;
    repeat (2) @(negedge clk);

    // Requester 3 drops req right after its grant; burst still runs.
    set_cnt(3, 4);
    req = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[3] && n < 10);
    check("gnt3_seen", 32'(gnt[3]), 32'd1);
    req = '0;
    wait_done(3, 20);
    repeat (2) @(negedge clk);

    // Maximum count, reset on the 5th toggle cycle.
    set_cnt(1, 15);
    req = 4'b0010;
    n = 0;
    v = 0;
    while (v < 5 && n < 30) begin
      @(negedge clk);
      n++;
      if (t) v++;
    end
    check("t_cycles_before_reset", v, 5);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_t", 32'(t), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic: requests hold until served, some drop mid-burst.
    repeat (1500) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_cnt(i, $urandom_range(0, 15));
        end else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          v = $urandom_range(0, 15);
          if ($urandom_range(0, 7) == 0) v = 15;
          if ($urandom_range(0, 7) == 0) v = 0;
          set_cnt(i, v);
          req[i] = 1'b1;
        end
      end
    end

    req = '0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("idle_at_end", 32'(busy), 32'd0);
`ifdef TFF_SCHED_STATS_EN
    check("toggle_total", 32'(toggle_total), m_total);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
